cordic_rotation_engine: RTL and testbench

- Iterative rotation-mode CORDIC stage directly downstream of the angle pre-processing unit.
- Consumes a quadrant-reduced angle (±π/2, Q2.14 radians, π/2 = 25736) plus the cos-negate flag.
- Produces cos/sin in Q2.14, 1.0 = 16384, with the quadrant correction applied to cos.
- One micro-rotation per clock; single-entry, non-pipelined; start/done handshake.

---
 rtl/cordic_pkg.sv | 40 ++++
 rtl/cordic_rotation_engine_if.sv | 24 ++
 rtl/cordic_microrotation.sv | 36 +++
 rtl/cordic_rotation_engine.sv | 120 ++++++++++++
 tb/tb_cordic_rotation_engine.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/cordic_pkg.sv
// Shared constants, state encoding and arctangent table for the CORDIC rotation engine.
// All angle and trig values are Q2.14 (1.0 = 16384, pi/2 = 25736).
package cordic_pkg;

  localparam int DATA_W     = 16;
  localparam int HEADROOM_W = 2;

  localparam int ANGLE_PI_2 = 25736;
  localparam int ANGLE_PI   = 51472;
  localparam int CORDIC_K   = 9950;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROTATE,
    S_FINISH
  } state_t;

  // round(atan(2^-i) * 2^14); caller scales by the guard bits
  function automatic logic [DATA_W-1:0] atan_lut(input logic [3:0] idx);
    case (idx)
      4'd0:    atan_lut = 16'd12868;
      4'd1:    atan_lut = 16'd7596;
      4'd2:    atan_lut = 16'd4014;
      4'd3:    atan_lut = 16'd2037;
      4'd4:    atan_lut = 16'd1023;
      4'd5:    atan_lut = 16'd512;
      4'd6:    atan_lut = 16'd256;
      4'd7:    atan_lut = 16'd128;
      4'd8:    atan_lut = 16'd64;
      4'd9:    atan_lut = 16'd32;
      4'd10:   atan_lut = 16'd16;
      4'd11:   atan_lut = 16'd8;
      4'd12:   atan_lut = 16'd4;
      4'd13:   atan_lut = 16'd2;
      4'd14:   atan_lut = 16'd1;
      default: atan_lut = 16'd0;
    endcase
  endfunction

endpackage

// File: rtl/cordic_rotation_engine_if.sv
// Start/done request bus of the CORDIC rotation engine.
// The requester uses the master modport, the engine uses the slave modport.
interface cordic_rotation_engine_if;
  import cordic_pkg::*;

  logic                     start;
  logic signed [DATA_W-1:0] reduced_angle;
  logic                     cos_negate;
  logic                     busy;
  logic                     done;
  logic signed [DATA_W-1:0] cos_out;
  logic signed [DATA_W-1:0] sin_out;

  modport master (
    output start, reduced_angle, cos_negate,
    input  busy, done, cos_out, sin_out
  );

  modport slave (
    input  start, reduced_angle, cos_negate,
    output busy, done, cos_out, sin_out
  );

endinterface

// File: rtl/cordic_microrotation.sv
// One combinational CORDIC micro-rotation; the rotation direction follows the sign of z.
module cordic_microrotation
  import cordic_pkg::*;
#(
  parameter int DP_W  = 20,
  parameter int GUARD = 2
) (
  input  logic signed [DP_W-1:0] x,
  input  logic signed [DP_W-1:0] y,
  input  logic signed [DP_W-1:0] z,
  input  logic [3:0]             idx,
  output logic signed [DP_W-1:0] x_nxt,
  output logic signed [DP_W-1:0] y_nxt,
  output logic signed [DP_W-1:0] z_nxt
);

  logic signed [DP_W-1:0] x_sh;
  logic signed [DP_W-1:0] y_sh;
  logic signed [DP_W-1:0] atan_step;

  always_comb begin
    x_sh      = x >>> idx;
    y_sh      = y >>> idx;
    atan_step = DP_W'(atan_lut(idx)) <<< GUARD;
    if (!z[DP_W-1]) begin
      x_nxt = x - y_sh;
      y_nxt = y + x_sh;
      z_nxt = z - atan_step;
    end else begin
      x_nxt = x + y_sh;
      y_nxt = y - x_sh;
      z_nxt = z + atan_step;
    end
  end

endmodule

// File: rtl/cordic_rotation_engine.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock, start/done handshake.
// Build option CORDIC_ROUND_EN: round half-up and saturate outputs instead of truncating.
//   state    | meaning
//   S_IDLE   | waiting for start, results held
//   S_ROTATE | one micro-rotation per cycle, ITER cycles
//   S_FINISH | results valid, done pulse
module cordic_rotation_engine
  import cordic_pkg::*;
#(
  parameter int ITER  = 16,
  parameter int GUARD = 2
) (
  input logic                     clk,
  input logic                     rst,
  cordic_rotation_engine_if.slave bus
);

  localparam int         DP_W = DATA_W + GUARD + HEADROOM_W;
  localparam logic [3:0] LAST = 4'(ITER - 1);

`ifdef CORDIC_ROUND_EN
  localparam logic signed [DP_W-1:0] RND    = DP_W'((GUARD > 0) ? 2 ** (GUARD - 1) : 0);
  localparam logic signed [DP_W-1:0] SAT_HI = DP_W'(16384);
  localparam logic signed [DP_W-1:0] SAT_LO = -DP_W'(16384);
`endif

  state_t                   state;
  state_t                   state_nxt;
  logic signed [DP_W-1:0]   x, y, z;
  logic signed [DP_W-1:0]   x_nxt, y_nxt, z_nxt;
  logic [3:0]               iter_cnt;
  logic                     neg;
  logic signed [DATA_W-1:0] cos_q;
  logic signed [DATA_W-1:0] sin_q;
  logic signed [DATA_W-1:0] cos_c;

  function automatic logic signed [DATA_W-1:0] conv(input logic signed [DP_W-1:0] v);
    logic signed [DP_W-1:0] r;
`ifdef CORDIC_ROUND_EN
    r = (v + RND) >>> GUARD;
    if (r > SAT_HI)      r = SAT_HI;
    else if (r < SAT_LO) r = SAT_LO;
`else
    r = v >>> GUARD;
`endif
    return r[DATA_W-1:0];
  endfunction

  cordic_microrotation #(
    .DP_W  (DP_W),
    .GUARD (GUARD)
  ) u_micro (
    .x     (x),
    .y     (y),
    .z     (z),
    .idx   (iter_cnt),
    .x_nxt (x_nxt),
    .y_nxt (y_nxt),
    .z_nxt (z_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (bus.start) state_nxt = S_ROTATE;
      S_ROTATE: if (iter_cnt == LAST) state_nxt = S_FINISH;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign cos_c = conv(x_nxt);

  // Results are registered off the last rotation so they are valid during S_FINISH.
  always_ff @(posedge clk) begin
    if (rst) begin
      x        <= '0;
      y        <= '0;
      z        <= '0;
      iter_cnt <= '0;
      neg      <= 1'b0;
      cos_q    <= '0;
      sin_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            x        <= DP_W'(CORDIC_K) <<< GUARD;
            y        <= '0;
            z        <= DP_W'(bus.reduced_angle) <<< GUARD;
            neg      <= bus.cos_negate;
            iter_cnt <= '0;
          end
        end
        S_ROTATE: begin
          x        <= x_nxt;
          y        <= y_nxt;
          z        <= z_nxt;
          iter_cnt <= iter_cnt + 4'd1;
          if (iter_cnt == LAST) begin
            cos_q <= neg ? -cos_c : cos_c;
            sin_q <= conv(y_nxt);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (state != S_IDLE);
  assign bus.done    = (state == S_FINISH);
  assign bus.cos_out = cos_q;
  assign bus.sin_out = sin_q;

endmodule

// File: tb/tb_cordic_rotation_engine.sv
// Directed bench for cordic_rotation_engine: known angles, handshake corner cases, reset abort.
module tb_cordic_rotation_engine;
  import cordic_pkg::*;

  localparam int TOL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  cordic_rotation_engine_if bus ();

  cordic_rotation_engine #(
    .ITER  (16),
    .GUARD (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp, input int tol);
    int diff;
    diff = got - exp;
    if (diff < 0) diff = -diff;
    n_cmp++;
    if (diff > tol) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  // Start in cycle 1; returns the cycle number in which done is seen, -1 on timeout.
  task automatic run_op(input logic signed [15:0] ang, input logic neg, output int lat);
    lat = -1;
    @(negedge clk);
    bus.start         = 1'b1;
    bus.reduced_angle = ang;
    bus.cos_negate    = neg;
    for (int n = 2; n <= 60; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) begin
        lat = n;
        break;
      end
    end
  endtask

  typedef struct {
    string            name;
    logic signed [15:0] ang;
    logic             neg;
    int               cos_exp;
    int               sin_exp;
  } vec_t;

  vec_t vecs[4] = '{
    '{"ang0",      16'sd0,      1'b0, 16384,  0},
    '{"pi_2",      16'sd25736,  1'b0, 0,      16384},
    '{"m_pi_4",   -16'sd12868,  1'b0, 11585, -11585},
    '{"3pi_4",     16'sd12868,  1'b1, -11585, 11585}
  };

  initial begin
    int lat;
    int ndone;
    int dcyc;
    int c_cos;
    int c_sin;
    int busy_after;
    int late_done;

    bus.start         = 1'b0;
    bus.reduced_angle = '0;
    bus.cos_negate    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_busy", int'(bus.busy), 0, 0);
    check_val("rst_done", int'(bus.done), 0, 0);
    check_val("rst_cos",  int'(bus.cos_out), 0, 0);
    check_val("rst_sin",  int'(bus.sin_out), 0, 0);
    rst = 1'b0;

    foreach (vecs[k]) begin
      run_op(vecs[k].ang, vecs[k].neg, lat);
      check_val({vecs[k].name, "_lat"}, lat, 18, 0);
      check_val({vecs[k].name, "_cos"}, int'(bus.cos_out), vecs[k].cos_exp, TOL);
      check_val({vecs[k].name, "_sin"}, int'(bus.sin_out), vecs[k].sin_exp, TOL);
      if (k == 0) begin
        @(negedge clk);
        check_val("done_pulse", int'(bus.done), 0, 0);
        check_val("cos_hold", int'(bus.cos_out), 16384, TOL);
      end
    end

    // Out-of-range angle must still terminate on schedule.
    run_op(16'sd32767, 1'b0, lat);
    check_val("oor_lat", lat, 18, 0);

    // Starts while busy and in the done cycle are ignored; the next cycle accepts.
    ndone = 0; dcyc = 0; c_cos = 0; c_sin = 0; busy_after = -1;
    @(negedge clk);
    bus.start         = 1'b1;
    bus.reduced_angle = 16'sd25736;
    bus.cos_negate    = 1'b0;
    for (int c = 2; c <= 40; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (dcyc != 0 && c == dcyc + 1) begin
        busy_after        = int'(bus.busy);
        bus.start         = 1'b1;
        bus.reduced_angle = -16'sd12868;
        bus.cos_negate    = 1'b0;
        break;
      end
      if (bus.done) begin
        ndone++;
        dcyc  = c;
        c_cos = int'(bus.cos_out);
        c_sin = int'(bus.sin_out);
        bus.start         = 1'b1;
        bus.reduced_angle = 16'sd0;
        bus.cos_negate    = 1'b1;
      end
      if (c == 4 || c == 11) begin
        bus.start         = 1'b1;
        bus.reduced_angle = 16'sd0;
        bus.cos_negate    = 1'b1;
      end
    end
    check_val("ign_ndone", ndone, 1, 0);
    check_val("ign_dcyc", dcyc, 18, 0);
    check_val("ign_cos", c_cos, 0, TOL);
    check_val("ign_sin", c_sin, 16384, TOL);
    check_val("done_cyc_start_ignored", busy_after, 0, 0);
    @(negedge clk);
    bus.start = 1'b0;
    check_val("accept_next", int'(bus.busy), 1, 0);
    lat = -1;
    for (int n = 3; n <= 60; n++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = n;
        break;
      end
    end
    check_val("acc_lat", lat, 18, 0);
    check_val("acc_cos", int'(bus.cos_out), 11585, TOL);
    check_val("acc_sin", int'(bus.sin_out), -11585, TOL);

    // Reset in the fifth ROTATE cycle aborts with no done.
    @(negedge clk);
    bus.start         = 1'b1;
    bus.reduced_angle = 16'sd0;
    bus.cos_negate    = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("abort_busy", int'(bus.busy), 0, 0);
    check_val("abort_cos", int'(bus.cos_out), 0, 0);
    check_val("abort_sin", int'(bus.sin_out), 0, 0);
    late_done = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.done) late_done++;
    end
    check_val("abort_no_done", late_done, 0, 0);
    run_op(16'sd25736, 1'b1, lat);
    check_val("post_lat", lat, 18, 0);
    check_val("post_cos", int'(bus.cos_out), 0, TOL);
    check_val("post_sin", int'(bus.sin_out), 16384, TOL);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
